dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DMEM_SIZE, default 1024, data memory depth in 32-bit words; SHALL be a power of two.
REQ-002 CLK  input  1  sole clock; all state SHALL update on posedge CLK.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 c_req  input  1  CPU port request.
REQ-005 c_we  input  1  CPU port write (1) / read (0).
REQ-006 c_adr  input  32  CPU port byte address.
REQ-007 c_wdata  input  32  CPU port store data.
REQ-008 c_gnt  output  1  CPU request accepted this cycle.
REQ-009 c_rvalid  output  1  CPU read response valid.
REQ-010 c_err  output  1  CPU response is an error, qualified by c_rvalid.
REQ-011 d_req, d_we, d_adr, d_wdata, d_gnt, d_rvalid, d_err: DMA port signals, same widths and meanings as the CPU port.
REQ-012 rdata  output  32  response data shared by both ports.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_adr  output  log2(DMEM_SIZE)  memory word index.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  memory read data, valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-018 Each port's request SHALL be held stable until that port's gnt is sampled high; a request is accepted in the cycle gnt=1.
REQ-019 Grant logic SHALL be combinational from the requests and the round-robin pointer; at most one gnt SHALL be high per cycle.
REQ-020 Arbitration: if only one port requests, that port SHALL be granted; if both request, the port not granted most recently SHALL win.
REQ-021 The round-robin pointer SHALL update only on a grant and SHALL record the granted port; it resets to "DMA last", so the CPU wins the first contention.
REQ-022 Word index SHALL be adr>>2, truncated to log2(DMEM_SIZE) bits.
REQ-023 A request SHALL be an error if adr[1:0] != 0 or adr>>2 >= DMEM_SIZE; an erroneous request SHALL still be granted but SHALL NOT assert mem_en.
REQ-024 A valid granted request SHALL drive mem_en=1, mem_we=we, mem_adr and mem_wdata from the granted port in the same cycle; otherwise mem_en=0, mem_we=0.
REQ-025 Response stage: a one-entry register SHALL capture {port, is_read, err} on every grant; the matching rvalid SHALL assert exactly one cycle after the grant for valid reads and for all errors.
REQ-026 Valid writes SHALL produce no rvalid.
REQ-027 On a valid read response, rdata SHALL equal mem_rdata and err SHALL be 0; on an error response, rdata SHALL be 32'h0 and err SHALL be 1.
REQ-028 When no response is active, rdata SHALL be 32'h0 and both rvalid outputs SHALL be 0.
REQ-029 Throughput: back-to-back grants SHALL be possible every cycle; a new grant SHALL be allowed in the same cycle as the previous grant's response.
REQ-030 A read and a write to the same word in consecutive grants SHALL be ordered by grant order, with no forwarding inside the block.

Reset
REQ-031 While RST=0: gnt, rvalid, err, mem_en and mem_we SHALL be 0; rdata, mem_adr and mem_wdata SHALL be 0; the pointer SHALL be "DMA last"; the response register SHALL be empty.
REQ-032 Reset asserted mid-transaction SHALL discard any pending response; no rvalid SHALL appear after reset is released until a new grant occurs.

Verification
REQ-033 Reset, then c_req=1, c_we=1, c_adr=0x10, c_wdata=0xDEADBEEF -> same cycle: c_gnt=1, mem_en=1, mem_we=1, mem_adr=4; next cycle: no rvalid.
REQ-034 Then c_req=1, c_we=0, c_adr=0x10 -> c_gnt=1; next cycle: c_rvalid=1, rdata=0xDEADBEEF, c_err=0.
REQ-035 c_req and d_req both held high for 4 cycles after reset -> grants in order C, D, C, D; responses routed to the matching port one cycle later.
REQ-036 d_req read at d_adr=0x3 -> d_gnt=1, mem_en=0; next cycle: d_rvalid=1, d_err=1, rdata=0. Repeat with d_adr=DMEM_SIZE*4 -> same error response.
REQ-037 A valid read is granted, then RST is pulsed low before the next edge -> after release, c_rvalid stays 0 and the pointer is back to "DMA last".

Source files
------------

// File: rtl/dm_arbiter_if.sv
//------------------------------------------------------------------------------
// dm_arbiter_if
//   Bundle of the CPU/DMA request ports, the shared response bus and the
//   single-port data-memory strobes served by dm_arbiter.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dm_arbiter_if #(
  parameter int unsigned DMEM_SIZE = 1024
);
  localparam int unsigned ADR_W = $clog2(DMEM_SIZE);

  // CPU port
  logic              c_req;
  logic              c_we;
  logic [31:0]       c_adr;
  logic [31:0]       c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic              c_err;

  // DMA port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_adr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic              d_err;

  // Shared response data
  logic [31:0]       rdata;

  // Data memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADR_W-1:0]  mem_adr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Environment side: requesters plus the memory macro
  modport master (
    output c_req, c_we, c_adr, c_wdata,
    input  c_gnt, c_rvalid, c_err,
    output d_req, d_we, d_adr, d_wdata,
    input  d_gnt, d_rvalid, d_err,
    input  rdata,
    input  mem_en, mem_we, mem_adr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side
  modport slave (
    input  c_req, c_we, c_adr, c_wdata,
    output c_gnt, c_rvalid, c_err,
    input  d_req, d_we, d_adr, d_wdata,
    output d_gnt, d_rvalid, d_err,
    output rdata,
    output mem_en, mem_we, mem_adr, mem_wdata,
    input  mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/dm_arbiter.sv
//------------------------------------------------------------------------------
// dm_arbiter
//   Two-port (CPU, DMA) round-robin arbiter in front of a single-port data
//   memory with one-cycle read latency. Grants are combinational, responses
//   come out of a one-entry register one cycle after the grant.
//   DMEM_SIZE must be a power of two.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_arbiter #(
  parameter int unsigned DMEM_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  localparam int unsigned ADR_W = $clog2(DMEM_SIZE);

  // Misaligned or beyond the end of memory
  function automatic logic adr_err(input logic [31:0] adr);
    return (adr[1:0] != 2'b00) || ((adr >> 2) >= 32'(DMEM_SIZE));
  endfunction

  // Round-robin pointer: 1 = DMA was granted last
  logic        last_dma_q, last_dma_d;
  // Response register {occupied, port, is_read, err}
  logic        rsp_occ_q,  rsp_occ_d;
  logic        rsp_dma_q,  rsp_dma_d;
  logic        rsp_read_q, rsp_read_d;
  logic        rsp_err_q,  rsp_err_d;

  logic        w_c_win;
  logic        w_d_win;
  logic        w_gnt;
  logic        w_sel_we;
  logic [31:0] w_sel_adr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_err;
  logic        w_rsp_act;

  // Grant selection and granted-port mux; grants are forced low in reset
  always_comb begin
    w_c_win     = rst_n & bus.c_req & (~bus.d_req | last_dma_q);
    w_d_win     = rst_n & bus.d_req & (~bus.c_req | ~last_dma_q);
    w_gnt       = w_c_win | w_d_win;
    w_sel_we    = w_d_win ? bus.d_we    : bus.c_we;
    w_sel_adr   = w_d_win ? bus.d_adr   : bus.c_adr;
    w_sel_wdata = w_d_win ? bus.d_wdata : bus.c_wdata;
    w_sel_err   = adr_err(w_sel_adr);
  end

  // Next state: pointer follows the granted port, response slot reloads each cycle
  always_comb begin
    last_dma_d = last_dma_q;
    if (w_gnt) begin
      last_dma_d = w_d_win;
    end
    rsp_occ_d  = w_gnt;
    rsp_dma_d  = w_d_win;
    rsp_read_d = ~w_sel_we;
    rsp_err_d  = w_sel_err;
  end

  // State registers; reset discards any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dma_q <= 1'b1;
      rsp_occ_q  <= 1'b0;
      rsp_dma_q  <= 1'b0;
      rsp_read_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      last_dma_q <= last_dma_d;
      rsp_occ_q  <= rsp_occ_d;
      rsp_dma_q  <= rsp_dma_d;
      rsp_read_q <= rsp_read_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Memory strobes and grant outputs; erroneous requests never touch memory
  always_comb begin
    bus.c_gnt     = w_c_win;
    bus.d_gnt     = w_d_win;
    bus.mem_en    = w_gnt & ~w_sel_err;
    bus.mem_we    = w_gnt & ~w_sel_err & w_sel_we;
    bus.mem_adr   = w_gnt ? w_sel_adr[ADR_W+1:2] : '0;
    bus.mem_wdata = w_gnt ? w_sel_wdata : 32'h0;
  end

  // Response routing: valid writes stay silent, errors return zero data
  always_comb begin
    w_rsp_act    = rsp_occ_q & (rsp_read_q | rsp_err_q);
    bus.c_rvalid = w_rsp_act & ~rsp_dma_q;
    bus.d_rvalid = w_rsp_act &  rsp_dma_q;
    bus.c_err    = w_rsp_act & ~rsp_dma_q & rsp_err_q;
    bus.d_err    = w_rsp_act &  rsp_dma_q & rsp_err_q;
    bus.rdata    = (w_rsp_act & ~rsp_err_q) ? bus.mem_rdata : 32'h0;
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
//------------------------------------------------------------------------------
// tb_dm_arbiter
//   Directed scenarios followed by constrained-random traffic on both ports,
//   checked each cycle against a transaction-level reference model.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_arbiter;

  localparam int unsigned DMEM = 1024;

  logic clk;
  logic rst_n;

  dm_arbiter_if #(.DMEM_SIZE(DMEM)) bus ();

  dm_arbiter #(.DMEM_SIZE(DMEM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro: one-cycle read latency
  logic [31:0] mem [DMEM];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_wdata;
      else            bus.mem_rdata    <= mem[bus.mem_adr];
    end
  end

  int vectors;
  int miscompares;

  // Reference model state
  logic [31:0] ref_mem [DMEM];
  int          last_port;     // 0 = CPU, 1 = DMA
  bit          pend_v;
  int          pend_port;
  bit          pend_err;
  logic [31:0] pend_data;
  bit          exp_cg;
  bit          exp_dg;
  int          grant_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_port = 1;
    pend_v    = 1'b0;
    exp_cg    = 1'b0;
    exp_dg    = 1'b0;
  endtask

  // One clock: check at negedge against the model, advance model, return at posedge+1
  task automatic cycle();
    int          win;
    bit          gnt;
    bit          err;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    @(negedge clk);
    win = -1;
    if (bus.c_req && bus.d_req) win = (last_port == 1) ? 0 : 1;
    else if (bus.c_req)         win = 0;
    else if (bus.d_req)         win = 1;
    gnt = (win >= 0);
    we  = 1'b0;
    adr = 32'h0;
    wd  = 32'h0;
    if (win == 0) begin we = bus.c_we; adr = bus.c_adr; wd = bus.c_wdata; end
    if (win == 1) begin we = bus.d_we; adr = bus.d_adr; wd = bus.d_wdata; end
    err = gnt && (((adr % 4) != 0) || ((adr / 4) >= DMEM));

    chk("c_gnt",  32'(bus.c_gnt),  32'(win == 0));
    chk("d_gnt",  32'(bus.d_gnt),  32'(win == 1));
    chk("mem_en", 32'(bus.mem_en), 32'(gnt && !err));
    chk("mem_we", 32'(bus.mem_we), 32'(gnt && !err && we));
    if (gnt && !err) chk("mem_adr", 32'(bus.mem_adr), adr / 4);
    if (gnt && !err && we) chk("mem_wdata", bus.mem_wdata, wd);

    chk("c_rvalid", 32'(bus.c_rvalid), 32'(pend_v && pend_port == 0));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(pend_v && pend_port == 1));
    chk("rdata", bus.rdata, (pend_v && !pend_err) ? pend_data : 32'h0);
    if (pend_v && pend_port == 0) chk("c_err", 32'(bus.c_err), 32'(pend_err));
    if (pend_v && pend_port == 1) chk("d_err", 32'(bus.d_err), 32'(pend_err));

    pend_v    = gnt && (err || !we);
    pend_port = win;
    pend_err  = err;
    pend_data = (gnt && !err) ? ref_mem[adr / 4] : 32'h0;
    if (gnt && !err && we) ref_mem[adr / 4] = wd;
    if (gnt) begin
      last_port = win;
      grant_log.push_back(win);
    end
    exp_cg = (win == 0);
    exp_dg = (win == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input bit req, input bit we, input logic [31:0] adr, input logic [31:0] wd);
    bus.c_req = req; bus.c_we = we; bus.c_adr = adr; bus.c_wdata = wd;
  endtask

  task automatic set_d(input bit req, input bit we, input logic [31:0] adr, input logic [31:0] wd);
    bus.d_req = req; bus.d_we = we; bus.d_adr = adr; bus.d_wdata = wd;
  endtask

  // Mid-cycle reset pulse; outputs must be quiet while it is low
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_c_rvalid", 32'(bus.c_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    chk("rst_c_gnt",    32'(bus.c_gnt),    32'h0);
    chk("rst_mem_en",   32'(bus.mem_en),   32'h0);
    chk("rst_rdata",    bus.rdata,         32'h0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_adr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    if (k == 1) return 32'(DMEM * 4 + $urandom_range(0, 255) * 4);
    return 32'($urandom_range(0, 15) * 4);
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < int'(DMEM); i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bus.mem_rdata = 32'h0;
    model_reset();

    // Reset state with a valid request already presented
    rst_n = 1'b0;
    set_c(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    set_d(1'b1, 1'b0, 32'h24, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_c_gnt",     32'(bus.c_gnt),     32'h0);
    chk("reset_d_gnt",     32'(bus.d_gnt),     32'h0);
    chk("reset_mem_en",    32'(bus.mem_en),    32'h0);
    chk("reset_mem_we",    32'(bus.mem_we),    32'h0);
    chk("reset_mem_adr",   32'(bus.mem_adr),   32'h0);
    chk("reset_mem_wdata", bus.mem_wdata,      32'h0);
    chk("reset_rdata",     bus.rdata,          32'h0);
    chk("reset_c_rvalid",  32'(bus.c_rvalid),  32'h0);
    chk("reset_d_rvalid",  32'(bus.d_rvalid),  32'h0);
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CPU write then read-back of word 4
    set_c(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    cycle();
    set_c(1'b1, 1'b0, 32'h10, 32'h0);
    cycle();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // Contention straight after reset: C, D, C, D
    pulse_reset();
    grant_log.delete();
    set_c(1'b1, 1'b0, 32'h10, 32'h0);
    set_d(1'b1, 1'b1, 32'h14, 32'hCAFE_F00D);
    repeat (4) cycle();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    chk("order_len", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      chk($sformatf("order_%0d", i), 32'(grant_log[i]), 32'(i % 2));
    end

    // DMA error responses: misaligned, then one past the end
    set_d(1'b1, 1'b0, 32'h3, 32'h0);
    cycle();
    set_d(1'b1, 1'b0, 32'(DMEM * 4), 32'h0);
    cycle();
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // Reset between a read grant and its response
    set_c(1'b1, 1'b0, 32'h10, 32'h0);
    cycle();
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    pulse_reset();
    cycle();
    set_c(1'b1, 1'b0, 32'h14, 32'h0);
    set_d(1'b1, 1'b0, 32'h10, 32'h0);
    cycle();
    chk("post_reset_cpu_first", 32'(grant_log[grant_log.size() - 1]), 32'd0);

    // Random traffic, each port holding its request until granted
    for (int i = 0; i < 600; i++) begin
      if (!(bus.c_req && !exp_cg)) set_c($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_adr(), $urandom);
      if (!(bus.d_req && !exp_dg)) set_d($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_adr(), $urandom);
      cycle();
    end
    set_c(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
